// File: rtl/drum_tone_sequencer_pkg.sv
// Package: drum_tone_pkg
// Shared types, voice tables and the saturating Top-update helper for the
// drum tone sequencer.
//   tone_state_t : sequencer state (IDLE, SWEEP, HOLD)
//   VOICE_START  : initial Top value per pad
//   VOICE_DELTA  : signed Top change applied at each sweep step per pad
//   MIN_TOP      : lowest Top value a sweep may reach
//   sat_add      : Top + delta, clamped to [MIN_TOP, 16'hFFFF]
package drum_tone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } tone_state_t;

    localparam logic [15:0]        VOICE_START [4] = '{16'h2000, 16'h0800, 16'h0200, 16'h0100};
    localparam logic signed [15:0] VOICE_DELTA [4] = '{16'sh0100, 16'sh0020, 16'sh0004, -16'sd2};
    localparam logic [15:0]        MIN_TOP = 16'h0010;

    // The sum is formed with two spare bits so that neither an unsigned
    // overflow past 16'hFFFF nor a negative result can alias into range.
    function automatic logic [15:0] sat_add(input logic [15:0] base,
                                            input logic signed [15:0] delta);
        logic signed [17:0] sum;
        sum = $signed({2'b00, base}) + $signed({{2{delta[15]}}, delta});
        if (sum > 18'sd65535)
            return 16'hFFFF;
        else if (sum < $signed({2'b00, MIN_TOP}))
            return MIN_TOP;
        else
            return sum[15:0];
    endfunction

endpackage

// File: rtl/drum_tone_sequencer_step_timer.sv
// Module: tone_step_timer
// Free-running step timer counting 0..STEP_CYCLES-1 and wrapping.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; zeroes the count and masks tick this cycle
//   tick  : high for the one cycle in which the count wraps
module tone_step_timer #(
    parameter int STEP_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST) && !clr;

endmodule

// File: rtl/drum_tone_sequencer.sv
// Module: drum_tone_sequencer
// Turns a pad hit strobe into a timed pitch sweep of PWM Top values:
// sweep NUM_STEPS deltas, hold HOLD_STEPS steps, then fall silent.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   hit     : one-cycle pad strobe
//   pad_id  : voice select, used only in the hit cycle
//   top     : Top value for the PWM generator, 0 when silent
//   tone_en : high during SWEEP and HOLD
//   busy    : same as tone_en
//   done    : one-cycle pulse when a tone ends naturally
//
// state | meaning
// IDLE  | silent, waiting for a hit
// SWEEP | top moves by the voice delta at every step boundary
// HOLD  | top frozen at its final value until the hold time expires
module drum_tone_sequencer
    import drum_tone_pkg::*;
#(
    parameter int STEP_CYCLES = 50000,
    parameter int NUM_STEPS   = 16,
    parameter int HOLD_STEPS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hit,
    input  logic [1:0]  pad_id,
    output logic [15:0] top,
    output logic        tone_en,
    output logic        busy,
    output logic        done
);

    localparam int MAX_STEPS = (NUM_STEPS > HOLD_STEPS) ? NUM_STEPS : HOLD_STEPS;
    localparam int CNT_W     = $clog2(MAX_STEPS + 1);
    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_STEPS - 1);

    tone_state_t      state, state_n;
    logic [1:0]       voice, voice_n;
    logic [CNT_W-1:0] step_cnt, step_cnt_n;
    logic [15:0]      top_q, top_n;
    logic             en_q, en_n;
    logic             done_q, done_n;
    logic             tick;
    logic             timer_clr;

    // Timer restarts on every hit so the first boundary lands a full step
    // after the reload; it is held clear while idle.
    assign timer_clr = hit || (state == IDLE);

    tone_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            voice    <= 2'd0;
            step_cnt <= '0;
            top_q    <= 16'h0000;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            voice    <= voice_n;
            step_cnt <= step_cnt_n;
            top_q    <= top_n;
            en_q     <= en_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        voice_n    = voice;
        step_cnt_n = step_cnt;
        top_n      = top_q;
        done_n     = 1'b0;

        // A hit wins over any step boundary in the same cycle.
        if (hit) begin
            state_n    = SWEEP;
            voice_n    = pad_id;
            step_cnt_n = '0;
            top_n      = VOICE_START[pad_id];
        end else begin
            case (state)
                SWEEP: begin
                    if (tick) begin
                        top_n = sat_add(top_q, VOICE_DELTA[voice]);
                        if (step_cnt == SWEEP_LAST) begin
                            state_n    = HOLD;
                            step_cnt_n = '0;
                        end else begin
                            step_cnt_n = step_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (step_cnt == HOLD_LAST) begin
                            state_n    = IDLE;
                            step_cnt_n = '0;
                            top_n      = 16'h0000;
                            done_n     = 1'b1;
                        end else begin
                            step_cnt_n = step_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n    = IDLE;
                    step_cnt_n = '0;
                    top_n      = 16'h0000;
                end
            endcase
        end

        en_n = (state_n != IDLE);
    end

    assign top     = top_q;
    assign tone_en = en_q;
    assign busy    = en_q;
    assign done    = done_q;

endmodule
